// File: rtl/ext_pipe.sv
// ext_pipe: immediate-extension unit with a small result FIFO.
//
// A request (imm, eop, tag) is accepted on in_valid & in_ready. The immediate is
// extended combinationally according to eop and {data, tag, err} is written into
// the FIFO tail on the rising edge. Results drain through out_valid / out_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   request present
//   in_ready   request accepted when high together with in_valid
//   imm        immediate, IMM_W bits
//   eop        extension mode (000 sext, 001 zext, 010 load-upper,
//              011 sext<<SHAMT, 100 zext<<SHAMT, others illegal)
//   tag        sideband tag, returned with the result
//   out_valid  FIFO head valid
//   out_ready  consumer takes head this cycle
//   out_data   extended result at head (0 when out_valid=0)
//   out_tag    tag at head (0 when out_valid=0)
//   out_err    head came from an illegal eop (0 when out_valid=0)
//   count      FIFO occupancy
module ext_pipe #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHAMT  = 2,
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IMM_W-1:0]         imm,
    input  logic [2:0]               eop,
    input  logic [TAG_W-1:0]         tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned U     = DATA_W - IMM_W;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Extension datapath
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] ext_data;
    logic              ext_err;

    always_comb begin
        zext     = DATA_W'(imm);
        sext     = DATA_W'($signed(imm));
        ext_data = '0;
        ext_err  = 1'b0;
        case (eop)
            3'b000:  ext_data = sext;
            3'b001:  ext_data = zext;
            3'b010:  ext_data = zext << U;
            3'b011:  ext_data = sext << SHAMT;
            3'b100:  ext_data = zext << SHAMT;
            default: begin
                ext_data = '0;
                ext_err  = 1'b1;
            end
        endcase
    end

    // FIFO control
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_fire;
    logic             out_fire;
    logic             full;

    always_comb begin
        out_valid = (count_q != '0);
        out_fire  = out_valid & out_ready;
        full      = (count_q == FULL_CNT);
        // A pop frees the slot the push needs, so a full FIFO still accepts.
        in_ready  = ~full | out_fire;
        in_fire   = in_valid & in_ready;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({in_fire, out_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];
    logic              mem_err  [DEPTH];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_data[wr_ptr_q] <= ext_data;
            mem_tag[wr_ptr_q]  <= tag;
            mem_err[wr_ptr_q]  <= ext_err;
        end
    end

    always_comb begin
        out_data = '0;
        out_tag  = '0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_data = mem_data[rd_ptr_q];
            out_tag  = mem_tag[rd_ptr_q];
            out_err  = mem_err[rd_ptr_q];
        end
        count = count_q;
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed bench for ext_pipe with a queue-based reference model
// checked every falling edge, plus literal expectations on the directed vectors.
module tb_ext_pipe;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SHAMT  = 2;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DEPTH  = 2;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [IMM_W-1:0]  imm;
    logic [2:0]        eop;
    logic [TAG_W-1:0]  tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;
    logic [$clog2(DEPTH):0] count;

    ext_pipe #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W),
        .SHAMT  (SHAMT),
        .TAG_W  (TAG_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .eop       (eop),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit en       = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the immediate's numeric value.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } ent_t;

    ent_t q[$];

    function automatic ent_t model(input logic [IMM_W-1:0] i, input logic [2:0] e,
                                   input logic [TAG_W-1:0] t);
        ent_t   r;
        longint sv;
        longint v;
        longint half = longint'(1) << (IMM_W - 1);
        sv = (longint'(i) >= half) ? longint'(i) - 2 * half : longint'(i);
        r.err = 1'b0;
        case (e)
            3'd0:    v = sv;
            3'd1:    v = longint'(i);
            3'd2:    v = longint'(i) * (longint'(1) << (DATA_W - IMM_W));
            3'd3:    v = sv * (longint'(1) << SHAMT);
            3'd4:    v = longint'(i) * (longint'(1) << SHAMT);
            default: begin
                v     = 0;
                r.err = 1'b1;
            end
        endcase
        r.data = v[DATA_W-1:0];
        r.tag  = t;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            bit exp_ready;
            bit pop;
            pop       = (q.size() != 0) && out_ready;
            exp_ready = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (in_valid && exp_ready) q.push_back(model(imm, eop, tag));
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (en) begin
            ent_t h;
            bit   v;
            v = (q.size() != 0);
            h.data = '0;
            h.tag  = '0;
            h.err  = 1'b0;
            if (v) h = q[0];
            chk("m_out_valid", 64'(out_valid), 64'(v));
            chk("m_count", 64'(count), 64'(q.size()));
            chk("m_in_ready", 64'(in_ready),
                64'((q.size() < DEPTH) || (v && out_ready)));
            chk("m_out_data", 64'(out_data), 64'(h.data));
            chk("m_out_tag", 64'(out_tag), 64'(h.tag));
            chk("m_out_err", 64'(out_err), 64'(h.err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request into an empty FIFO with out_ready=1, then observe the pop.
    task automatic push_pop(input logic [IMM_W-1:0] i, input logic [2:0] e,
                            input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] exp_d,
                            input logic exp_e);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        imm       = i;
        eop       = e;
        tag       = t;
        #1;
        chk("pp_in_ready", 64'(in_ready), 64'(1));
        chk("pp_no_bypass", 64'(out_valid), 64'(0));
        step();
        in_valid = 1'b0;
        imm      = 'x;
        eop      = 'x;
        tag      = 'x;
        #1;
        chk("pp_valid", 64'(out_valid), 64'(1));
        chk("pp_count1", 64'(count), 64'(1));
        chk("pp_data", 64'(out_data), 64'(exp_d));
        chk("pp_tag", 64'(out_tag), 64'(t));
        chk("pp_err", 64'(out_err), 64'(exp_e));
        step();
        #1;
        chk("pp_valid_fall", 64'(out_valid), 64'(0));
        chk("pp_count0", 64'(count), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        imm       = '0;
        eop       = '0;
        tag       = '0;
        #1;
        reset = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step();

        // Reset state
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_tag", 64'(out_tag), 64'(0));
        chk("rst_err", 64'(out_err), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Modes
        push_pop(16'h8000, 3'b000, 5'd1, 32'hFFFF8000, 1'b0);
        push_pop(16'h8000, 3'b001, 5'd2, 32'h00008000, 1'b0);
        push_pop(16'h8000, 3'b010, 5'd3, 32'h80000000, 1'b0);
        push_pop(16'hFFFF, 3'b011, 5'd4, 32'hFFFFFFFC, 1'b0);
        push_pop(16'hFFFF, 3'b100, 5'd5, 32'h0003FFFC, 1'b0);
        push_pop(16'h1234, 3'b011, 5'd6, 32'h000048D0, 1'b0);
        push_pop(16'h7FFF, 3'b000, 5'd7, 32'h00007FFF, 1'b0);

        // Illegal modes
        push_pop(16'h1234, 3'b111, 5'd17, 32'h00000000, 1'b1);
        push_pop(16'hABCD, 3'b101, 5'd30, 32'h00000000, 1'b1);

        // Back-pressure: three requests, out_ready low
        out_ready = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            in_valid = 1'b1;
            imm      = 16'(t * 16'h0111);
            eop      = 3'b001;
            tag      = 5'(t);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(t <= 2 ? 1 : 0));
            step();
        end
        chk("bp_count", 64'(count), 64'(2));
        chk("bp_stall_data0", 64'(out_data), 64'h00000111);
        step();
        chk("bp_stall_data1", 64'(out_data), 64'h00000111);
        chk("bp_stall_tag", 64'(out_tag), 64'(1));
        chk("bp_stall_ready", 64'(in_ready), 64'(0));

        // Full push + pop in the same cycle (request tag 3 still held)
        out_ready = 1'b1;
        #1;
        chk("fp_in_ready", 64'(in_ready), 64'(1));
        chk("fp_head_tag", 64'(out_tag), 64'(1));
        step();
        in_valid = 1'b0;
        #1;
        chk("fp_count", 64'(count), 64'(2));
        chk("fp_tag2", 64'(out_tag), 64'(2));
        chk("fp_data2", 64'(out_data), 64'h00000222);
        step();
        chk("fp_tag3", 64'(out_tag), 64'(3));
        chk("fp_data3", 64'(out_data), 64'h00000333);
        chk("fp_count1", 64'(count), 64'(1));
        step();
        chk("fp_empty", 64'(out_valid), 64'(0));

        // Reset mid-stream with count=2
        out_ready = 1'b0;
        for (int t = 5; t <= 6; t++) begin
            in_valid = 1'b1;
            imm      = 16'h00F0;
            eop      = 3'b000;
            tag      = 5'(t);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("mr_count_pre", 64'(count), 64'(2));
        #1;
        reset = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'(0));
        chk("mr_count", 64'(count), 64'(0));
        chk("mr_data", 64'(out_data), 64'(0));
        chk("mr_tag", 64'(out_tag), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("mr_ready_after", 64'(in_ready), 64'(1));
        chk("mr_valid_after", 64'(out_valid), 64'(0));
        push_pop(16'h0001, 3'b000, 5'd9, 32'h00000001, 1'b0);
        step();
        chk("mr_no_stale", 64'(out_valid), 64'(0));

        en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
